alu_share_arbiter: RTL and testbench

- Shares one combinational 64-bit ALU between two requesters, e.g. the execute stage (port 0) and the branch/address unit (port 1).
- Arbitrates between them, registers the chosen operands and drives the ALU control code and operands.
- Captures the result and flag and returns them over a valid/ready response handshake.
- One operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
// A request is arbitrated and latched. The ALU is driven for one cycle, and
// its result is returned to the granted port over a valid/ready handshake.
// Optional statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic             req0_src,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req0_imm,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic             req1_src,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [WIDTH-1:0] req1_imm,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_flag,
    output logic             resp_err,
    output logic             busy,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_rs,
    output logic [WIDTH-1:0] alu_rt,
    output logic [WIDTH-1:0] alu_ds,
    input  logic [WIDTH-1:0] alu_result,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
    output logic [7:0]       err_cnt,
`endif
    input  logic             alu_flag
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             pref;
    logic             lat_id;
    logic             grant_id;
    logic             accept;
    logic             sel_legal;
    logic             resp_hs;
    logic [3:0]       sel_op;
    logic             sel_src;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_imm;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    endfunction

    // Grant selection, request mux, handshakes and next-state decode
    always_comb begin
        state_next = state;
        if (RR_EN && pref) begin
            grant_id = req1_valid ? 1'b1 : 1'b0;
        end else begin
            grant_id = req0_valid ? 1'b0 : 1'b1;
        end
        accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
        sel_op     = grant_id ? req1_op  : req0_op;
        sel_src    = grant_id ? req1_src : req0_src;
        sel_a      = grant_id ? req1_a   : req0_a;
        sel_b      = grant_id ? req1_b   : req0_b;
        sel_imm    = grant_id ? req1_imm : req0_imm;
        sel_legal  = op_legal(sel_op);
        resp_hs    = (state == RESP) && (lat_id ? resp1_ready : resp0_ready);
        resp0_valid = (state == RESP) && !lat_id;
        resp1_valid = (state == RESP) && lat_id;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_legal ? ISSUE : RESP;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, latched request, ALU drive registers, response capture and pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pref        <= 1'b0;
            lat_id      <= 1'b0;
            resp_result <= '0;
            resp_flag   <= 1'b0;
            resp_err    <= 1'b0;
            alu_src     <= 1'b0;
            alu_op      <= 4'b0000;
            alu_rs      <= '0;
            alu_rt      <= '0;
            alu_ds      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_id <= grant_id;
                if (sel_legal) begin
                    alu_op  <= sel_op;
                    alu_src <= sel_src;
                    alu_rs  <= sel_a;
                    alu_rt  <= sel_b;
                    alu_ds  <= sel_imm;
                end else begin
                    resp_result <= '0;
                    resp_flag   <= 1'b0;
                    resp_err    <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                resp_result <= alu_result;
                resp_flag   <= (alu_op == OP_SUB) && alu_flag;
                resp_err    <= 1'b0;
            end
            if (resp_hs && RR_EN) begin
                pref <= ~lat_id;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating grant and illegal-op counters
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else if (accept) begin
            if (!grant_id && grant_cnt0 != 16'hFFFF) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (grant_id && grant_cnt1 != 16'hFFFF) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
            if (!sel_legal && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. It instantiates a round-robin instance
// and a fixed-priority instance that receive the same stimulus, together with
// a behavioural ALU model. Expected responses are queued when a request is
// accepted and are compared when the response appears.
module tb_alu_share_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, req0_src, req1_src;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
    logic         resp0_ready, resp1_ready;

    logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [W-1:0] resp_result;
    logic         resp_flag, resp_err, busy, alu_src, alu_flag;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_rs, alu_rt, alu_ds, alu_result;

    logic         fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid;
    logic [W-1:0] fp_resp_result;
    logic         fp_resp_flag, fp_resp_err, fp_busy, fp_alu_src, fp_alu_flag;
    logic [3:0]   fp_alu_op;
    logic [W-1:0] fp_alu_rs, fp_alu_rt, fp_alu_ds, fp_alu_result;

`ifdef ALU_ARB_STATS_EN
    logic [15:0]  grant_cnt0, grant_cnt1, fp_grant_cnt0, fp_grant_cnt1;
    logic [7:0]   err_cnt, fp_err_cnt;
`endif

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         flag;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] aluModel(input logic [3:0] op, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        case (op)
            4'b0010: aluModel = x + y;
            4'b0110: aluModel = x - y;
            4'b0000: aluModel = x & y;
            4'b0001: aluModel = x | y;
            4'b1100: aluModel = ~(x | y);
            4'b0111: aluModel = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            default: aluModel = '0;
        endcase
    endfunction

    assign alu_result    = aluModel(alu_op, alu_rs, alu_src ? alu_ds : alu_rt);
    assign alu_flag      = (alu_result == '0);
    assign fp_alu_result = aluModel(fp_alu_op, fp_alu_rs, fp_alu_src ? fp_alu_ds : fp_alu_rt);
    assign fp_alu_flag   = (fp_alu_result == '0);

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_src(req0_src),
        .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_src(req1_src),
        .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_flag(resp_flag), .resp_err(resp_err), .busy(busy),
        .alu_src(alu_src), .alu_op(alu_op), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_ds(alu_ds),
        .alu_result(alu_result),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt),
`endif
        .alu_flag(alu_flag)
    );

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_src(req0_src),
        .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_src(req1_src),
        .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
        .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(fp_resp_result), .resp_flag(fp_resp_flag), .resp_err(fp_resp_err),
        .busy(fp_busy),
        .alu_src(fp_alu_src), .alu_op(fp_alu_op), .alu_rs(fp_alu_rs), .alu_rt(fp_alu_rt),
        .alu_ds(fp_alu_ds), .alu_result(fp_alu_result),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0(fp_grant_cnt0), .grant_cnt1(fp_grant_cnt1), .err_cnt(fp_err_cnt),
`endif
        .alu_flag(fp_alu_flag)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request on a single port, check the accept and the ISSUE cycle.
    // On return the DUT is expected to be in RESP.
    task automatic applyStimulus(input logic id, input logic [3:0] op, input logic src,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] imm, input logic [W-1:0] exp_res,
                                 input logic exp_flag, input logic exp_err);
        exp_t e;
        if (id) begin
            req1_op = op; req1_src = src; req1_a = a; req1_b = b; req1_imm = imm; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_src = src; req0_a = a; req0_b = b; req0_imm = imm; req0_valid = 1'b1;
        end
        #1;
        checkOutput("accept_ready", id ? req1_ready : req0_ready, 1);
        checkOutput("other_ready", id ? req0_ready : req1_ready, 0);
        e.id = id; e.result = exp_res; e.flag = exp_flag; e.err = exp_err;
        sb.push_back(e);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
        if (!exp_err) begin
            checkOutput("issue_alu_op", alu_op, op);
            checkOutput("issue_alu_rs", alu_rs, a);
            checkOutput("issue_no_valid", id ? resp1_valid : resp0_valid, 0);
            step();
        end
    endtask

    // Check the response against the scoreboard, optionally holding it for some cycles.
    task automatic collectResponse(input logic id, input int hold);
        exp_t e;
        checkOutput("resp_valid", id ? resp1_valid : resp0_valid, 1);
        checkOutput("resp_other_valid", id ? resp0_valid : resp1_valid, 0);
        if (sb.size() == 0) begin
            checkOutput("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        checkOutput("resp_id", id, e.id);
        checkOutput("resp_result", resp_result, e.result);
        checkOutput("resp_flag", resp_flag, e.flag);
        checkOutput("resp_err", resp_err, e.err);
        if (hold > 0) begin
            if (id) begin resp0_ready = 1'b1; req0_valid = 1'b1; end
            else    begin resp1_ready = 1'b1; req1_valid = 1'b1; end
        end
        for (int i = 0; i < hold; i++) begin
            #1;
            checkOutput("hold_valid", id ? resp1_valid : resp0_valid, 1);
            checkOutput("hold_result", resp_result, e.result);
            checkOutput("hold_no_accept", req0_ready | req1_ready, 0);
            checkOutput("hold_busy", busy, 1);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        checkOutput("idle_after_resp", busy, 0);
    endtask

    initial begin
        int   k;
        int   seen_resp;
        logic rr_exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_src = 1'b0; req1_src = 1'b0;
        req0_op = '0; req1_op = '0;
        req0_a = '0; req0_b = '0; req0_imm = '0; req1_a = '0; req1_b = '0; req1_imm = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        repeat (2) step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", {req0_ready, req1_ready}, 0);
        checkOutput("rst_valid", {resp0_valid, resp1_valid}, 0);
        checkOutput("rst_result", resp_result, 0);
        checkOutput("rst_flags", {resp_flag, resp_err}, 0);
        checkOutput("rst_alu_op", {alu_src, alu_op}, 0);
        checkOutput("rst_alu_ops", alu_rs | alu_rt | alu_ds, 0);
`ifdef ALU_ARB_STATS_EN
        checkOutput("rst_cnt", {grant_cnt0, grant_cnt1, err_cnt}, 0);
`endif
        reset = 1'b0;
        step();

        $display("[TB] illegal opcode on port 0");
        applyStimulus(1'b0, 4'b1111, 1'b0, 64'd3, 64'd4, 64'd5, 64'd0, 1'b0, 1'b1);
        checkOutput("illegal_alu_hold", alu_op, 0);
`ifdef ALU_ARB_STATS_EN
        checkOutput("err_cnt", err_cnt, 1);
        checkOutput("grant_cnt0", grant_cnt0, 1);
`endif
        collectResponse(1'b0, 0);

        $display("[TB] single-port operations");
        applyStimulus(1'b0, 4'b0010, 1'b0, 64'd5, 64'd7, 64'd99, 64'd12, 1'b0, 1'b0);
        collectResponse(1'b0, 0);
        applyStimulus(1'b1, 4'b0110, 1'b1, 64'h10, 64'h99, 64'h10, 64'd0, 1'b1, 1'b0);
        collectResponse(1'b1, 0);
        applyStimulus(1'b1, 4'b0110, 1'b1, 64'h10, 64'h99, 64'h11, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        collectResponse(1'b1, 0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 64'hF0, 64'h0F, 64'h0, 64'd0, 1'b0, 1'b0);
        collectResponse(1'b0, 0);
        applyStimulus(1'b1, 4'b0111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd1, 1'b0, 1'b0);
        collectResponse(1'b1, 0);
        applyStimulus(1'b0, 4'b1100, 1'b0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        collectResponse(1'b0, 0);

        $display("[TB] held response on port 1");
        applyStimulus(1'b1, 4'b0001, 1'b0, 64'hA0, 64'h05, 64'h0, 64'hA5, 1'b0, 1'b0);
        collectResponse(1'b1, 5);

        $display("[TB] contention: round-robin and fixed priority");
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0_op = 4'b0010; req0_src = 1'b0; req0_a = 64'd1; req0_b = 64'd1;
        req1_op = 4'b0010; req1_src = 1'b0; req1_a = 64'd2; req1_b = 64'd2;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0;
        seen_resp = 0;
        for (int c = 0; c < 40; c++) begin
            exp_t e;
            #1;
            if (resp0_valid || resp1_valid) begin
                seen_resp++;
                if (sb.size() == 0) begin
                    checkOutput("rr_sb_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rr_resp_id", resp1_valid, e.id);
                    checkOutput("rr_resp_result", resp_result, e.result);
                end
            end
            if (req0_ready || req1_ready) begin
                if (k < 4) begin
                    checkOutput("rr_grant", req1_ready, rr_exp[k]);
                end
                checkOutput("fp_grant0", fp_req0_ready, 1);
                checkOutput("fp_grant1", fp_req1_ready, 0);
                e.id = req1_ready; e.result = req1_ready ? 64'd4 : 64'd2; e.flag = 1'b0; e.err = 1'b0;
                sb.push_back(e);
                k++;
            end
            step();
            if (k >= 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            if (k >= 4 && seen_resp >= 4) break;
        end
        checkOutput("rr_grant_count", k, 4);
        checkOutput("rr_resp_count", seen_resp, 4);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        sb.delete();
        repeat (3) step();

        $display("[TB] reset during ISSUE");
        applyStimulus(1'b0, 4'b0010, 1'b0, 64'd1, 64'd2, 64'd0, 64'd3, 1'b0, 1'b0);
        collectResponse(1'b0, 0);
        req1_op = 4'b0000; req1_src = 1'b0; req1_a = 64'd6; req1_b = 64'd3; req1_valid = 1'b1;
        #1;
        checkOutput("abort_accept", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        checkOutput("abort_in_issue", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_no_valid", {resp0_valid, resp1_valid}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checkOutput("abort_ptr0", req0_ready, 1);
        checkOutput("abort_ptr1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (resp0_valid || resp1_valid || busy) k++;
        end
        checkOutput("abort_no_resp", k, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
